// File: rtl/sw_sqrt_sched_pkg.sv
// Shared types and default widths for the switch-to-sqrt poll scheduler.
package sw_sqrt_sched_pkg;

   localparam int DATA_W_DEF = 10;
   localparam int RES_W_DEF  = 5;

   typedef enum logic [2:0] {
      S_IDLE,
      S_RD_REQ,
      S_RD_CAP,
      S_START,
      S_WAIT_DONE
   } state_t;

endpackage

// File: rtl/poll_tick_gen.sv
// Free-running poll period counter; tick is high on the terminal count.
module poll_tick_gen #(
   parameter int POLL_DIV = 50000
) (
   input  logic i_clk,
   input  logic i_reset,
   output logic o_tick
);

   localparam int CW = $clog2(POLL_DIV);

   logic [CW-1:0] r_cnt;
   logic          w_tc;

   assign w_tc   = (r_cnt == CW'(POLL_DIV - 1));
   assign o_tick = w_tc;

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_cnt <= '0;
      end else if (w_tc) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

endmodule

// File: rtl/sw_sqrt_poll_sched.sv
// Polls the switch PIO, launches a sqrt on operand change, holds the root.
module sw_sqrt_poll_sched
   import sw_sqrt_sched_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int RES_W    = RES_W_DEF,
   parameter int POLL_DIV = 50000,
   parameter int TIMEOUT  = 1024
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic              i_enable,
   output logic [1:0]        o_avm_address,
   output logic              o_avm_read,
   input  logic [31:0]       i_avm_readdata,
   output logic              o_sqrt_start,
   output logic [DATA_W-1:0] o_sqrt_operand,
   input  logic              i_sqrt_done,
   input  logic [RES_W-1:0]  i_sqrt_result,
   output logic [RES_W-1:0]  o_result,
   output logic              o_result_valid,
   output logic              o_result_update,
   output logic              o_timeout_err
);

   localparam int TW = $clog2(TIMEOUT);

   state_t              r_state;
   state_t              w_next;
   logic                r_pend;
   logic                r_read;
   logic                r_start;
   logic [DATA_W-1:0]   r_op;
   logic [TW-1:0]       r_to_cnt;
   logic [RES_W-1:0]    r_res;
   logic                r_valid;
   logic                r_upd;
   logic                r_terr;
   logic                w_tick;
   logic                w_to_hit;
   logic [DATA_W-1:0]   w_new_op;
   logic                w_unused_rd;

   poll_tick_gen #(
      .POLL_DIV (POLL_DIV)
   ) u_tick (
      .i_clk   (i_clk),
      .i_reset (i_reset),
      .o_tick  (w_tick)
   );

   assign w_new_op    = i_avm_readdata[DATA_W-1:0];
   assign w_unused_rd = ^i_avm_readdata[31:DATA_W];
   assign w_to_hit    = (r_to_cnt == TW'(TIMEOUT - 1));

   always_comb begin
      w_next = r_state;
      unique case (r_state)
         S_IDLE: begin
            if ((w_tick || r_pend) && i_enable) begin
               w_next = S_RD_REQ;
            end
         end
         S_RD_REQ: w_next = S_RD_CAP;
         S_RD_CAP: begin
            if (r_valid && !r_terr && (w_new_op == r_op)) begin
               w_next = S_IDLE;
            end else begin
               w_next = S_START;
            end
         end
         S_START: w_next = S_WAIT_DONE;
         S_WAIT_DONE: begin
            if (i_sqrt_done || w_to_hit) begin
               w_next = S_IDLE;
            end
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Strobes are decoded from the next state so they line up with it.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state  <= S_IDLE;
         r_pend   <= 1'b0;
         r_read   <= 1'b0;
         r_start  <= 1'b0;
         r_op     <= '0;
         r_to_cnt <= '0;
         r_res    <= '0;
         r_valid  <= 1'b0;
         r_upd    <= 1'b0;
         r_terr   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_read  <= (w_next == S_RD_REQ);
         r_start <= (w_next == S_START);
         r_upd   <= 1'b0;
         if ((r_state == S_IDLE) && (w_next == S_RD_REQ)) begin
            r_pend <= 1'b0;
         end else if (w_tick && ((r_state != S_IDLE) || !i_enable)) begin
            r_pend <= 1'b1;
         end
         if ((r_state == S_RD_CAP) && (w_next == S_START)) begin
            r_op <= w_new_op;
         end
         if (r_state == S_START) begin
            r_to_cnt <= '0;
         end else if (r_state == S_WAIT_DONE) begin
            r_to_cnt <= r_to_cnt + 1'b1;
         end
         if (r_state == S_WAIT_DONE) begin
            if (i_sqrt_done) begin
               r_res   <= i_sqrt_result;
               r_valid <= 1'b1;
               r_upd   <= 1'b1;
               r_terr  <= 1'b0;
            end else if (w_to_hit) begin
               r_valid <= 1'b0;
               r_terr  <= 1'b1;
            end
         end
      end
   end

   assign o_avm_address   = 2'd0;
   assign o_avm_read      = r_read;
   assign o_sqrt_start    = r_start;
   assign o_sqrt_operand  = r_op;
   assign o_result        = r_res;
   assign o_result_valid  = r_valid;
   assign o_result_update = r_upd;
   assign o_timeout_err   = r_terr;

endmodule
